// File: rtl/sqdiff_pkg.sv
// Sizing helpers and the overflow-aware accumulate shared by the sqdiff datapath.
package sqdiff_pkg;

  // Widest accumulator the shared add helper can serve.
  localparam int SAT_MAXW = 128;

  typedef struct packed {
    logic                ovf;
    logic [SAT_MAXW-1:0] val;
  } sat_sum_t;

  function automatic int prod_width(input int width);
    return 2 * width + 2;
  endfunction

  function automatic int acc_width(input int width, input int vec_len);
    return prod_width(width) + $clog2(vec_len);
  endfunction

  // Adds x + y into a w-bit result; ovf is set when the true sum needs more
  // than w bits, and the result then clamps to all-ones or wraps.
  function automatic sat_sum_t sat_add(input logic [SAT_MAXW-1:0] x,
                                       input logic [SAT_MAXW-1:0] y,
                                       input int                  w,
                                       input logic                saturate);
    logic [SAT_MAXW:0] sum;
    logic [SAT_MAXW:0] mask;
    sat_sum_t          r;
    sum   = {1'b0, x} + {1'b0, y};
    mask  = ~((~(SAT_MAXW+1)'(0)) << w);
    r.ovf = |(sum & ~mask);
    r.val = SAT_MAXW'((r.ovf && saturate) ? mask : (sum & mask));
    return r;
  endfunction

endpackage

// File: rtl/sqdiff_mult.sv
// Operand regs, a+/-b pre-adder and square (DSP A/D, AD, M stages); 3-cycle latency.
// No backpressure; clr flushes every in-flight sample, including one offered that cycle.
module sqdiff_mult
  import sqdiff_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      in_valid,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  input  logic                      sub,
  output logic                      sq_valid,
  output logic        [2*WIDTH+1:0] sq_out
);

  localparam int PW = prod_width(WIDTH);

  logic                    v1, v2;
  logic signed [WIDTH-1:0] a1, b1;
  logic                    sub1;
  logic signed [WIDTH:0]   a1x, b1x, d_next, d2;
  logic signed [PW-1:0]    d2x;

  // One guard bit keeps a +/- b exact for every operand pair.
  assign a1x    = {a1[WIDTH-1], a1};
  assign b1x    = {b1[WIDTH-1], b1};
  assign d_next = sub1 ? (a1x - b1x) : (a1x + b1x);
  assign d2x    = {{(WIDTH+1){d2[WIDTH]}}, d2};

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      sq_valid <= 1'b0;
      sq_out   <= '0;
    end else begin
      v1       <= in_valid & ~clr;
      v2       <= v1 & ~clr;
      sq_valid <= v2 & ~clr;
      if (in_valid) begin
        a1   <= a;
        b1   <= b;
        sub1 <= sub;
      end
      if (v1) d2 <= d_next;
      // A flushed product must not disturb the held square either.
      if (v2 && !clr) sq_out <= d2x * d2x;
    end
  end

endmodule

// File: rtl/sqdiff_accum.sv
// (a +/- b)^2 summed over VEC_LEN valid samples; square after 3 cycles, frame result 4 cycles after its last sample.
// No backpressure: one sample per cycle, gaps allowed; frame_clr aborts the partial frame.
module sqdiff_accum
  import sqdiff_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int VEC_LEN   = 8,
  parameter int ACC_WIDTH = acc_width(WIDTH, VEC_LEN),
  parameter bit SATURATE  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  input  logic                        sub,
  input  logic                        frame_clr,
  output logic                        sq_valid,
  output logic        [2*WIDTH+1:0]   sq_out,
  output logic                        acc_valid,
  output logic        [ACC_WIDTH-1:0] acc_out,
  output logic                        acc_sat
);

  localparam int            CW   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

  logic [CW-1:0]        cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic                 frame_sat;
  sat_sum_t             nxt;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 sat_next;
  logic                 unused_hi;

  sqdiff_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk      (clk),
    .rst      (rst),
    .clr      (frame_clr),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .sq_valid (sq_valid),
    .sq_out   (sq_out)
  );

  // The first product of a frame loads rather than adds, so its own overflow
  // (narrow accumulator) is flagged through the same path.
  always_comb begin
    nxt      = sat_add((cnt == '0) ? '0 : SAT_MAXW'(acc), SAT_MAXW'(sq_out),
                       ACC_WIDTH, SATURATE);
    acc_next = nxt.val[ACC_WIDTH-1:0];
    sat_next = nxt.ovf | ((cnt != '0) & frame_sat);
  end

  assign unused_hi = ^nxt.val[SAT_MAXW-1:ACC_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      frame_sat <= 1'b0;
      acc_out   <= '0;
      acc_sat   <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      if (frame_clr) begin
        cnt       <= '0;
        acc       <= '0;
        frame_sat <= 1'b0;
      end else if (sq_valid) begin
        acc       <= acc_next;
        frame_sat <= sat_next;
        if (cnt == LAST) begin
          cnt       <= '0;
          acc_out   <= acc_next;
          acc_sat   <= sat_next;
          acc_valid <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sqdiff_accum.sv
// Randomised and directed checks of sqdiff_accum against a timeline model, on three accumulator configurations.
module tb_sqdiff_accum;

  localparam int W   = 16;
  localparam int VL  = 4;
  localparam int PW  = 2 * W + 2;
  localparam int AW0 = PW + $clog2(VL);
  localparam int NI  = 3;

  logic                clk = 1'b0;
  logic                rst, in_valid, sub, frame_clr;
  logic signed [W-1:0] a, b;

  logic          sqv  [NI];
  logic [PW-1:0] sqo  [NI];
  logic          accv [NI];
  logic          accs [NI];
  logic [AW0-1:0] acc0;
  logic [7:0]     acc1, acc2;

  always #5 clk = ~clk;

  sqdiff_accum #(.WIDTH(W), .VEC_LEN(VL), .SATURATE(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .sub(sub), .frame_clr(frame_clr),
    .sq_valid(sqv[0]), .sq_out(sqo[0]), .acc_valid(accv[0]), .acc_out(acc0), .acc_sat(accs[0]));
  sqdiff_accum #(.WIDTH(W), .VEC_LEN(VL), .ACC_WIDTH(8), .SATURATE(1'b0)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .sub(sub), .frame_clr(frame_clr),
    .sq_valid(sqv[1]), .sq_out(sqo[1]), .acc_valid(accv[1]), .acc_out(acc1), .acc_sat(accs[1]));
  sqdiff_accum #(.WIDTH(W), .VEC_LEN(VL), .ACC_WIDTH(8), .SATURATE(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .sub(sub), .frame_clr(frame_clr),
    .sq_valid(sqv[2]), .sq_out(sqo[2]), .acc_valid(accv[2]), .acc_out(acc2), .acc_sat(accs[2]));

  function automatic int aw_of(int i);
    return (i == 0) ? AW0 : 8;
  endfunction
  function automatic bit sat_of(int i);
    return (i != 1);
  endfunction
  function automatic logic [127:0] dacc(int i);
    if (i == 0) return 128'(acc0);
    if (i == 1) return 128'(acc1);
    return 128'(acc2);
  endfunction

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One entry per clock edge: what was offered and whether rst/clr hit it.
  typedef struct { bit v; int a; int b; bit sub; bit kill; } ev_t;
  ev_t hist[$];

  int           m_cnt;
  logic [127:0] m_acc     [NI];
  bit           m_fsat    [NI];
  logic [127:0] m_acc_out [NI];
  bit           m_acc_sat [NI];
  bit           m_accv, m_sqv;
  logic [127:0] m_sqo;

  function automatic logic [127:0] square(ev_t e);
    longint d;
    d = e.sub ? longint'(e.a - e.b) : longint'(e.a + e.b);
    return 128'(d * d);
  endfunction

  always @(posedge clk) begin
    ev_t          e;
    logic [127:0] p, s, lim;
    bit           ovf, last;
    cyc++;
    e.v = in_valid; e.a = a; e.b = b; e.sub = sub; e.kill = rst | frame_clr;
    hist.push_front(e);
    if (hist.size() > 4) void'(hist.pop_back());
    if (rst) begin
      m_cnt = 0; m_accv = 0; m_sqv = 0; m_sqo = '0;
      for (int i = 0; i < NI; i++) begin
        m_acc[i] = '0; m_fsat[i] = 0; m_acc_out[i] = '0; m_acc_sat[i] = 0;
      end
    end else begin
      m_accv = 0;
      // A sample offered 3 edges ago reaches the accumulator now unless rst/clr hit it on the way.
      if (frame_clr) begin
        m_cnt = 0;
        for (int i = 0; i < NI; i++) begin m_acc[i] = '0; m_fsat[i] = 0; end
      end else if (hist[3].v && !hist[3].kill && !hist[2].kill && !hist[1].kill) begin
        p    = square(hist[3]);
        last = (m_cnt == VL - 1);
        for (int i = 0; i < NI; i++) begin
          s   = ((m_cnt == 0) ? 128'(0) : m_acc[i]) + p;
          lim = 128'(1) << aw_of(i);
          ovf = (s >= lim);
          m_acc[i]  = !ovf ? s : (sat_of(i) ? lim - 128'(1) : (s & (lim - 128'(1))));
          m_fsat[i] = ovf || ((m_cnt != 0) && m_fsat[i]);
          if (last) begin m_acc_out[i] = m_acc[i]; m_acc_sat[i] = m_fsat[i]; end
        end
        if (last) begin m_cnt = 0; m_accv = 1; end
        else m_cnt++;
      end
      if (hist[2].v && !hist[2].kill && !hist[1].kill && !hist[0].kill) begin
        m_sqv = 1; m_sqo = square(hist[2]);
      end else begin
        m_sqv = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("u%0d sq_valid", i), 128'(sqv[i]), 128'(m_sqv));
        check($sformatf("u%0d sq_out", i), 128'(sqo[i]), m_sqo);
        check($sformatf("u%0d acc_valid", i), 128'(accv[i]), 128'(m_accv));
        check($sformatf("u%0d acc_out", i), dacc(i), m_acc_out[i]);
        if (m_accv) check($sformatf("u%0d acc_sat", i), 128'(accs[i]), 128'(m_acc_sat[i]));
      end
    end
  end

  // Record of completed frames for the directed literal checks.
  typedef struct { int inst; logic [127:0] acc; bit sat; int cyc; } rec_t;
  rec_t recq[$];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++)
      if (accv[i] === 1'b1) recq.push_back('{inst: i, acc: dacc(i), sat: accs[i], cyc: cyc});
  end

  function automatic int nrec(int inst);
    int n = 0;
    foreach (recq[k]) if (recq[k].inst == inst) n++;
    return n;
  endfunction

  function automatic rec_t getrec(int inst, int idx);
    rec_t r;
    int   n = 0;
    r = '{inst: -1, acc: '0, sat: 0, cyc: 0};
    foreach (recq[k]) begin
      if (recq[k].inst == inst) begin
        if (n == idx) r = recq[k];
        n++;
      end
    end
    return r;
  endfunction

  task automatic step(bit v, int av, int bv, bit s, bit clr, bit r = 1'b0);
    in_valid  = v;
    a         = W'(av);
    b         = W'(bv);
    sub       = s;
    frame_clr = clr;
    rst       = r;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  int diffs [8] = '{1, 2, 3, 4, 1, 1, 1, 1};

  initial begin
    ev_t  e0;
    rec_t r0, r1;
    bit   rv, rs, rc, rr;
    int   ra, rb;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; frame_clr = 1'b0;
    e0 = '{v: 0, a: 0, b: 0, sub: 0, kill: 1};
    for (int i = 0; i < 4; i++) hist.push_back(e0);
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    check("reset sq_valid", 128'(sqv[0]), 128'(0));
    check("reset sq_out", 128'(sqo[0]), 128'(0));
    check("reset acc_valid", 128'(accv[0]), 128'(0));
    check("reset acc_out", dacc(0), 128'(0));
    check("reset acc_sat", 128'(accs[0]), 128'(0));

    // Latency and pre-adder sign handling.
    step(1'b1, 5, 2, 1'b1, 1'b0);
    idle(1);
    check("latency sq_valid early", 128'(sqv[0]), 128'(0));
    idle(1);
    check("latency sq_valid", 128'(sqv[0]), 128'(1));
    check("sq 5-2", 128'(sqo[0]), 128'(9));
    step(1'b1, 5, 2, 1'b0, 1'b0);
    idle(2);
    check("sq 5+2", 128'(sqo[0]), 128'(49));
    step(1'b1, -32768, 32767, 1'b1, 1'b0);
    idle(2);
    check("sq extreme", 128'(sqo[0]), 128'h0000_0000_FFFE_0001);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    idle(3);

    // Back-to-back frames.
    recq.delete();
    foreach (diffs[k]) step(1'b1, diffs[k] + 7, 7, 1'b1, 1'b0);
    idle(6);
    r0 = getrec(0, 0);
    r1 = getrec(0, 1);
    check("b2b frames", 128'(nrec(0)), 128'(2));
    check("b2b frame0", r0.acc, 128'(30));
    check("b2b frame0 sat", 128'(r0.sat), 128'(0));
    check("b2b frame1", r1.acc, 128'(4));
    check("b2b spacing", 128'(r1.cyc - r0.cyc), 128'(4));

    // Saturate vs wrap in an 8-bit accumulator.
    recq.delete();
    for (int k = 0; k < 4; k++) step(1'b1, 13, 3, 1'b1, 1'b0);
    idle(6);
    r0 = getrec(0, 0);
    check("sat wide acc", r0.acc, 128'(400));
    check("sat wide flag", 128'(r0.sat), 128'(0));
    r0 = getrec(1, 0);
    check("wrap acc", r0.acc, 128'(144));
    check("wrap flag", 128'(r0.sat), 128'(1));
    r0 = getrec(2, 0);
    check("clamp acc", r0.acc, 128'(255));
    check("clamp flag", 128'(r0.sat), 128'(1));

    // Abort a partial frame; the sample offered with frame_clr is dropped.
    recq.delete();
    step(1'b1, 1, -2, 1'b1, 1'b0);
    step(1'b1, 1, -2, 1'b1, 1'b0);
    step(1'b1, 1, -2, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 1, 1, 1'b0, 1'b0);
    idle(6);
    r0 = getrec(0, 0);
    check("abort frames", 128'(nrec(0)), 128'(1));
    check("abort acc", r0.acc, 128'(16));

    // Reset mid-frame, then a gappy frame.
    recq.delete();
    step(1'b1, 5, 0, 1'b1, 1'b0);
    step(1'b1, 5, 0, 1'b1, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    check("midrst sq_valid", 128'(sqv[0]), 128'(0));
    check("midrst sq_out", 128'(sqo[0]), 128'(0));
    check("midrst acc_out", dacc(0), 128'(0));
    idle(6);
    check("midrst frames", 128'(nrec(0)), 128'(0));
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1, 0, 1'b1, 1'b0);
      idle(2);
    end
    idle(6);
    r0 = getrec(0, 0);
    check("gappy frames", 128'(nrec(0)), 128'(1));
    check("gappy acc", r0.acc, 128'(4));

    // Randomised traffic: small operands first, then full range.
    for (int n = 0; n < 3000; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      if (n < 1000) begin
        ra = int'($urandom_range(0, 40)) - 20;
        rb = int'($urandom_range(0, 40)) - 20;
      end else begin
        ra = int'($urandom_range(0, 65535)) - 32768;
        rb = int'($urandom_range(0, 65535)) - 32768;
      end
      rs = 1'($urandom_range(0, 1));
      rc = ($urandom_range(0, 39) == 0);
      rr = ($urandom_range(0, 299) == 0);
      step(rv, ra, rb, rs, rc, rr);
    end
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
